// File: rtl/clean_beats_mul_seq_if.sv
// Request/response and multiplier-cell bundle for clean_beats_mul_seq.
//   start/op/src1/src2 : request (driven by the environment)
//   busy/done/result   : status and registered result (driven by the sequencer)
//   cell_src1/cell_src2: operands toward the external 32x16 cell (sequencer)
//   cell_result        : cell output, low 32 bits of src1*src2[15:0] (environment)
interface clean_beats_mul_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic [31:0] cell_result;

  modport master (
    output start, op, src1, src2, cell_result,
    input  busy, done, result, cell_src1, cell_src2
  );

  modport slave (
    input  start, op, src1, src2, cell_result,
    output busy, done, result, cell_src1, cell_src2
  );
endinterface

// File: rtl/clean_beats_mul_seq.sv
// Multi-pass 32x32 multiplier sequencer built on an external 32x16 cell.
// op: 00 MUL (low word), 01 MULXUU, 10 MULXSS, 11 MULXSU (high words).
// MUL issues two passes (A * each B half); extended ops issue four
// half-by-half passes and form the unsigned 64-bit product, then apply a
// signed correction to the high word in the CORRECT cycle.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset, aborts any operation
//   bus   : clean_beats_mul_seq_if.slave (request, status, result, cell side)
// Parameter CELL_LATENCY (1..3): cycles from cell operands to cell_result.
module clean_beats_mul_seq #(
  parameter int CELL_LATENCY = 1
) (
  input logic                  clk,
  input logic                  reset,
  clean_beats_mul_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CORRECT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [1:0]  pass_q;
  logic [63:0] acc_q;
  logic [31:0] result_q;

  // One valid bit and pass tag per cycle of cell latency; the tail entry
  // says which pass the current cell_result belongs to.
  logic [CELL_LATENCY-1:0]      vld_pipe;
  logic [CELL_LATENCY-1:0][1:0] tag_pipe;

  logic        is_mul;
  logic [1:0]  last_idx;
  logic        issuing;
  logic        accept;
  logic        tail_vld;
  logic [1:0]  tail_tag;
  logic        last_beat;
  logic [5:0]  shamt;
  logic [63:0] partial;
  logic [31:0] uhi;
  logic [31:0] corrected;

  assign is_mul    = (op_q == 2'b00);
  assign last_idx  = is_mul ? 2'd1 : 2'd3;
  assign issuing   = (state_q == ISSUE);
  assign accept    = (state_q == IDLE) && bus.start;
  assign tail_vld  = vld_pipe[CELL_LATENCY-1];
  assign tail_tag  = tag_pipe[CELL_LATENCY-1];
  assign last_beat = tail_vld && (tail_tag == last_idx);

  // Pass weights: p0 -> 0, p1/p2 -> 16, p3 -> 32. MUL only uses p0/p1.
  always_comb begin
    shamt = 6'd0;
    case (tail_tag)
      2'd1, 2'd2: shamt = 6'd16;
      2'd3:       shamt = 6'd32;
      default:    shamt = 6'd0;
    endcase
  end

  assign partial = {32'h0, bus.cell_result} << shamt;
  assign uhi     = acc_q[63:32];

  // High-word correction turns the unsigned product into signed/mixed forms.
  always_comb begin
    corrected = acc_q[31:0];
    case (op_q)
      2'b01:   corrected = uhi;
      2'b10:   corrected = uhi - (a_q[31] ? b_q : 32'h0) - (b_q[31] ? a_q : 32'h0);
      2'b11:   corrected = uhi - (a_q[31] ? b_q : 32'h0);
      default: corrected = acc_q[31:0];
    endcase
  end

  // Cell operands: whole A against a B half for MUL; zero-extended halves
  // for extended ops (pass bit 0 selects A half, bit 1 selects B half).
  always_comb begin
    bus.cell_src1 = 32'h0;
    bus.cell_src2 = 32'h0;
    if (issuing) begin
      if (is_mul) begin
        bus.cell_src1 = a_q;
        bus.cell_src2 = {16'h0, pass_q[0] ? b_q[31:16] : b_q[15:0]};
      end else begin
        bus.cell_src1 = {16'h0, pass_q[0] ? a_q[31:16] : a_q[15:0]};
        bus.cell_src2 = {16'h0, pass_q[1] ? b_q[31:16] : b_q[15:0]};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ISSUE;
      ISSUE:   if (pass_q == last_idx) state_d = DRAIN;
      DRAIN:   if (last_beat) state_d = CORRECT;
      CORRECT: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      pass_q   <= 2'd0;
      acc_q    <= 64'h0;
      result_q <= 32'h0;
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      state_q <= state_d;

      vld_pipe[0] <= issuing;
      tag_pipe[0] <= pass_q;
      for (int i = 1; i < CELL_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end

      if (accept) begin
        op_q   <= bus.op;
        a_q    <= bus.src1;
        b_q    <= bus.src2;
        pass_q <= 2'd0;
        acc_q  <= 64'h0;
      end else begin
        if (issuing) pass_q <= pass_q + 2'd1;
        // Wraps modulo 2^64; carry out of bit 63 is dropped.
        if (tail_vld) acc_q <= acc_q + partial;
      end

      if (state_q == CORRECT) result_q <= corrected;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: doc/clean_beats_mul_seq.md
CLEAN_BEATS_MUL_SEQ -- requirements
Module: clean_beats_mul_seq

Interface
REQ-001 Parameter CELL_LATENCY, default 1: clocks from operands driven on cell_src1/cell_src2 to a valid cell_result; legal range 1..3.
REQ-002 clk  input  1  sole clock; all state rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 op  input  2  00 MUL (low word), 01 MULXUU, 10 MULXSS, 11 MULXSU (high words).
REQ-006 src1, src2  input  32 each  operands A and B; captured on the accepting edge.
REQ-007 busy  output  1  high from the cycle after acceptance until the done cycle, inclusive.
REQ-008 done  output  1  single-cycle completion pulse.
REQ-009 result  output  32  registered result; valid in the done cycle; held until the next done.
REQ-010 cell_src1, cell_src2  output  32 each  operands to the downstream 32x16 multiplier cell.
REQ-011 cell_result  input  32  cell output: low 32 bits of cell_src1 * cell_src2[15:0], unsigned.

Function
REQ-012 States SHALL be IDLE, ISSUE, DRAIN, CORRECT and DONE, with transitions as follows:
- IDLE->ISSUE when start=1.
- ISSUE->DRAIN after the last pass is issued.
- DRAIN->CORRECT when the last cell result is accumulated.
- CORRECT->DONE always.
- DONE->IDLE always.
REQ-013 A start while busy=1 SHALL be ignored, with no queuing.
REQ-014 Pass count N SHALL be 2 for MUL and 4 for the extended ops; one pass SHALL issue per ISSUE cycle, on consecutive cycles.
REQ-015 MUL passes (A = captured src1, B = captured src2) SHALL be:
- p0: cell_src1=A, cell_src2={16'h0,B[15:0]}.
- p1: cell_src1=A, cell_src2={16'h0,B[31:16]}.
- low = r0 + (r1<<16), modulo 2^32.
REQ-016 Extended passes SHALL use zero-extended halves, giving unsigned 32-bit partials:
- p0: AL*BL.
- p1: AH*BL.
- p2: AL*BH.
- p3: AH*BH.
- The partials SHALL accumulate into a 64-bit unsigned product U = r0 + (r1<<16) + (r2<<16) + (r3<<32).
REQ-017 Each cell_result SHALL be consumed exactly CELL_LATENCY cycles after its pass issues, tracked by a CELL_LATENCY-deep valid/tag shift register; no other stall is permitted.
REQ-018 The CORRECT cycle SHALL compute the output from Uhi = U[63:32] and U's low word:
- MULXUU: Uhi.
- MULXSS: Uhi - (A[31]?B:0) - (B[31]?A:0), modulo 2^32.
- MULXSU: Uhi - (A[31]?B:0).
- MUL: low word.
REQ-019 done SHALL assert exactly N + CELL_LATENCY + 2 cycles after the accepting cycle; with CELL_LATENCY=1 this is 5 cycles for MUL and 7 for extended ops.
REQ-020 result SHALL update only on the edge that enters DONE.
REQ-021 Outside ISSUE, cell_src1 and cell_src2 SHALL be 0.
REQ-022 A new start SHALL be accepted in the cycle after done (IDLE), giving a back-to-back throughput of one op per N + CELL_LATENCY + 3 cycles.
REQ-023 Accumulation SHALL be modulo 2^64; a carry out of bit 63 is discarded.

Reset
REQ-024 reset=1 SHALL force the following immediately and asynchronously, including mid-operation:
- state IDLE.
- busy=0, done=0, result=0.
- cell_src1=0, cell_src2=0.
- accumulator and latency shift register cleared.
REQ-025 An operation interrupted by reset SHALL be aborted, SHALL NOT produce done, and SHALL NOT be resumed.
REQ-026 After reset deasserts, the first start SHALL be accepted on the next rising edge at which start=1.

Verification
REQ-027 MUL A=0x00010001, B=0x00010001 -> done at cycle +5, result=0x00020001.
REQ-028 MULXUU A=B=0xFFFFFFFF -> result=0xFFFFFFFE at cycle +7; MULXSS with the same operands -> 0x00000000.
REQ-029 MULXSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF; MULXSS A=0x80000000, B=0x80000000 -> 0x40000000.
REQ-030 start pulsed during busy with different operands -> ignored; the original op's result is unchanged and exactly one done occurs.
REQ-031 reset asserted in the third ISSUE cycle of MULXUU -> busy, done and result are 0 at once; a following MUL 3*5 returns 0x0000000F at +5.
REQ-032 CELL_LATENCY=3 with a random 10k-op mix checked against a 64-bit reference model -> all results match, and done falls at N+5 cycles after each accepting cycle.
